// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control -- multicycle sequencer for the accumulator CPU.
//
// Each instruction is two bytes (opcode, operand) in program memory. The
// sequencer fetches both bytes, presents the latched opcode to the external
// decoder and then steps the datapath. A step can be a data memory read, an
// accumulator/flag load, a store or a jump.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   _iRun               1 = execute, 0 = pause at the next instruction boundary
//   _iProgData          program memory data, one cycle after _oProgAddr
//   _iDecode*           decoder results for _oInst (op, legal, imm, carry, ALU)
//   _iFlagZ/C/N         registered ALU flags, sampled in DECODE
//   _oProgAddr          program memory address
//   _oInst, _oOperand   latched opcode and operand
//   _oDataRE, _oDataWE  data memory read/write strobes, address = _oOperand
//   _oAccLoad           accumulator load pulse
//   _oFlagsLoad         flag register load pulse
//   _oAluSrcImm         ALU B source: 1 = _oOperand, 0 = data memory
//   _oUseCarry          ALU carry-in enable
//   _oHalted            sticky, set when an illegal opcode is executed
//
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
package cpu_control_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_LOAD, OP_STORE, OP_STOREI,
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR,
        OP_JUMP, OP_JZ, OP_JC, OP_JN
    } Operation;
endpackage

module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                _iRun,
    input  logic [7:0]          _iProgData,
    input  Operation            _iDecodeOp,
    input  logic                _iDecodeValid,
    input  logic                _iDecodeImm,
    input  logic                _iDecodeCarry,
    input  logic                _iDecodeALU,
    input  logic                _iFlagZ,
    input  logic                _iFlagC,
    input  logic                _iFlagN,
    output logic [PC_WIDTH-1:0] _oProgAddr,
    output logic [7:0]          _oInst,
    output logic [7:0]          _oOperand,
    output logic                _oDataRE,
    output logic                _oDataWE,
    output logic                _oAccLoad,
    output logic                _oFlagsLoad,
    output logic                _oAluSrcImm,
    output logic                _oUseCarry,
    output logic                _oHalted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_OP, S_FETCH_ARG, S_DECODE, S_MEM, S_EXEC, S_HALT
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [7:0]            inst_q, inst_d;
    logic [7:0]            operand_q, operand_d;
    // Instruction class and ALU controls captured in DECODE for use in EXEC.
    logic                  is_load_q, is_load_d;
    logic                  is_store_q, is_store_d;
    logic                  is_alu_q, is_alu_d;
    logic                  imm_q, imm_d;
    logic                  carry_q, carry_d;

    logic                  is_jump;
    logic                  jump_taken;

    // The 8-bit operand is zero-extended or truncated to the PC width.
    function automatic logic [PC_WIDTH-1:0] jump_target(input logic [7:0] arg);
        logic [PC_WIDTH+7:0] wide;
        wide = {{PC_WIDTH{1'b0}}, arg};
        return wide[PC_WIDTH-1:0];
    endfunction

    always_comb begin
        is_jump    = 1'b1;
        jump_taken = 1'b0;
        case (_iDecodeOp)
            OP_JUMP: jump_taken = 1'b1;
            OP_JZ:   jump_taken = _iFlagZ;
            OP_JC:   jump_taken = _iFlagC;
            OP_JN:   jump_taken = _iFlagN;
            default: is_jump    = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        operand_d   = operand_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        is_alu_d    = is_alu_q;
        imm_d       = imm_q;
        carry_d     = carry_q;

        _oProgAddr  = pc_q;
        _oDataRE    = 1'b0;
        _oDataWE    = 1'b0;
        _oAccLoad   = 1'b0;
        _oFlagsLoad = 1'b0;
        _oAluSrcImm = 1'b0;
        _oUseCarry  = 1'b0;
        _oHalted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (_iRun) state_d = S_FETCH_OP;
            end
            S_FETCH_OP: begin
                state_d = S_FETCH_ARG;
            end
            S_FETCH_ARG: begin
                // PC+1 wraps modulo 2**PC_WIDTH, so the last byte's operand comes from 0.
                _oProgAddr = pc_q + PC_WIDTH'(1);
                inst_d     = _iProgData;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                operand_d  = _iProgData;
                is_load_d  = (_iDecodeOp == OP_LOAD);
                is_store_d = (_iDecodeOp == OP_STORE) || (_iDecodeOp == OP_STOREI);
                is_alu_d   = _iDecodeALU;
                imm_d      = _iDecodeImm;
                carry_d    = _iDecodeCarry;
                if (!_iDecodeValid) begin
                    state_d = S_HALT;
                end else if (is_jump) begin
                    pc_d    = jump_taken ? jump_target(_iProgData) : pc_q + PC_WIDTH'(2);
                    state_d = _iRun ? S_FETCH_OP : S_IDLE;
                end else begin
                    pc_d = pc_q + PC_WIDTH'(2);
                    if (is_store_d)
                        state_d = S_EXEC;
                    else if ((_iDecodeALU || is_load_d) && _iDecodeImm)
                        state_d = S_EXEC;
                    else
                        state_d = S_MEM;
                end
            end
            S_MEM: begin
                _oDataRE = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                _oDataWE    = is_store_q;
                _oAccLoad   = !is_store_q && (is_alu_q || is_load_q);
                _oFlagsLoad = !is_store_q && is_alu_q;
                _oAluSrcImm = imm_q;
                _oUseCarry  = carry_q;
                state_d     = _iRun ? S_FETCH_OP : S_IDLE;
            end
            S_HALT: begin
                _oHalted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign _oInst    = inst_q;
    assign _oOperand = operand_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            operand_q  <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            is_alu_q   <= 1'b0;
            imm_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            operand_q  <= operand_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            is_alu_q   <= is_alu_d;
            imm_q      <= imm_d;
            carry_q    <= carry_d;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// Testbench for cpu_control. It provides a program memory model, an opcode
// decoder and a tiny flag register. The flags take operand[2:0] as {Z,C,N} on
// every flag load. An instruction-level reference model pushes the expected
// datapath events, with their cycle stamps, into a queue. A monitor pops the
// queue and compares whenever the DUT shows a strobe or raises _oHalted.
// -----------------------------------------------------------------------------
module tb_cpu_control;
    import cpu_control_pkg::*;

    typedef struct packed {
        logic     valid;
        logic     imm;
        logic     carry;
        logic     alu;
        Operation op;
    } dec_t;

    typedef struct packed {
        logic       re;
        logic       we;
        logic       acc;
        logic       flg;
        logic       imm;
        logic       carry;
        logic       halt;
        logic [7:0] inst;
        logic [7:0] op;
    } ev_t;

    typedef struct {
        ev_t ev;
        int  stamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] prog_data;
    logic [2:0] flags_q;
    dec_t       dv;

    logic [7:0] prog_addr, inst, operand;
    logic       re, we, accl, flgl, srcimm, usec, halted;

    logic [7:0] prog [256];
    logic [7:0] legal [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12,
                               8'h13, 8'h14, 8'h15, 8'h20, 8'h21, 8'h22, 8'h23};
    exp_t       exp_q [$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] m_pc;
    logic [2:0] m_flags;

    cpu_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        ._iRun        (run),
        ._iProgData   (prog_data),
        ._iDecodeOp   (dv.op),
        ._iDecodeValid(dv.valid),
        ._iDecodeImm  (dv.imm),
        ._iDecodeCarry(dv.carry),
        ._iDecodeALU  (dv.alu),
        ._iFlagZ      (flags_q[2]),
        ._iFlagC      (flags_q[1]),
        ._iFlagN      (flags_q[0]),
        ._oProgAddr   (prog_addr),
        ._oInst       (inst),
        ._oOperand    (operand),
        ._oDataRE     (re),
        ._oDataWE     (we),
        ._oAccLoad    (accl),
        ._oFlagsLoad  (flgl),
        ._oAluSrcImm  (srcimm),
        ._oUseCarry   (usec),
        ._oHalted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) prog_data <= prog[prog_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    flags_q <= '0;
        else if (flgl) flags_q <= operand[2:0];
    end

    function automatic dec_t decode(input logic [7:0] opc);
        dec_t d;
        d.valid = 1'b1; d.imm = 1'b0; d.carry = 1'b0; d.alu = 1'b0; d.op = OP_NOP;
        case (opc)
            8'h01: begin d.op = OP_LOAD;   d.imm = 1'b1; end
            8'h02: d.op = OP_LOAD;
            8'h03: d.op = OP_STORE;
            8'h04: begin d.op = OP_STOREI; d.imm = 1'b1; end
            8'h10: begin d.op = OP_ADD; d.alu = 1'b1; d.imm = 1'b1; end
            8'h11: begin d.op = OP_ADD; d.alu = 1'b1; end
            8'h12: begin d.op = OP_ADC; d.alu = 1'b1; d.imm = 1'b1; d.carry = 1'b1; end
            8'h13: begin d.op = OP_ADC; d.alu = 1'b1; d.carry = 1'b1; end
            8'h14: begin d.op = OP_SUB; d.alu = 1'b1; d.imm = 1'b1; end
            8'h15: begin d.op = OP_SUB; d.alu = 1'b1; end
            8'h20: d.op = OP_JUMP;
            8'h21: d.op = OP_JZ;
            8'h22: d.op = OP_JC;
            8'h23: d.op = OP_JN;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    always_comb dv = decode(inst);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endfunction

    function automatic void push(input logic r, input logic w, input logic a, input logic f,
                                 input logic im, input logic ca, input logic h,
                                 input logic [7:0] in, input logic [7:0] op, input int stamp);
        exp_t e;
        e.ev.re = r; e.ev.we = w; e.ev.acc = a; e.ev.flg = f;
        e.ev.imm = im; e.ev.carry = ca; e.ev.halt = h;
        e.ev.inst = in; e.ev.op = op;
        e.stamp = stamp;
        exp_q.push_back(e);
    endfunction

    // Instruction-level reference: runs n instructions from m_pc starting at
    // cycle t0 (first FETCH cycle); returns the cycle the next fetch starts.
    task automatic model_run(input int n, input int t0, output int t_end);
        int         t, e;
        logic [7:0] opc, arg, nxt;
        dec_t       d;
        logic       taken;
        t = t0;
        for (int i = 0; i < n; i++) begin
            nxt = m_pc + 8'd1;
            opc = prog[m_pc];
            arg = prog[nxt];
            d   = decode(opc);
            if (!d.valid) begin
                push(0, 0, 0, 0, 0, 0, 1, opc, arg, t + 3);
                t_end = t + 3;
                return;
            end
            if (d.op inside {OP_JUMP, OP_JZ, OP_JC, OP_JN}) begin
                case (d.op)
                    OP_JUMP: taken = 1'b1;
                    OP_JZ:   taken = m_flags[2];
                    OP_JC:   taken = m_flags[1];
                    default: taken = m_flags[0];
                endcase
                m_pc = taken ? arg : m_pc + 8'd2;
                t    = t + 3;
            end else if (d.op == OP_STORE || d.op == OP_STOREI) begin
                push(0, 1, 0, 0, d.imm, d.carry, 0, opc, arg, t + 3);
                m_pc = m_pc + 8'd2;
                t    = t + 4;
            end else begin
                e = t + 3;
                if (!d.imm) begin
                    push(1, 0, 0, 0, 0, 0, 0, opc, arg, e);
                    e = e + 1;
                end
                push(0, 0, 1, d.alu, d.imm, d.carry, 0, opc, arg, e);
                if (d.alu) m_flags = arg[2:0];
                m_pc = m_pc + 8'd2;
                t    = e + 1;
            end
        end
        t_end = t;
    endtask

    // Monitor: one comparison of event content and one of its cycle per event.
    initial begin
        ev_t  obs;
        exp_t e;
        logic ex, halted_prev;
        halted_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ex = accl | we | flgl;
                if (re | ex | (halted & !halted_prev)) begin
                    obs.re = re; obs.we = we; obs.acc = accl; obs.flg = flgl;
                    obs.imm = ex ? srcimm : 1'b0;
                    obs.carry = ex ? usec : 1'b0;
                    obs.halt = halted & !halted_prev;
                    obs.inst = inst; obs.op = operand;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", obs, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event", 64'(obs), 64'(e.ev));
                        chk("event_cycle", 64'(cyc), 64'(e.stamp));
                    end
                end
            end
            halted_prev = halted;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic apply_reset(input logic run_v);
        @(negedge clk);
        rst_n   = 1'b0;
        m_pc    = 8'h00;
        m_flags = 3'b000;
        repeat (2) @(negedge clk);
        run   = run_v;
        rst_n = 1'b1;
    endtask

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc < t) begin
            @(negedge clk);
            guard++;
            if (guard > 10000) begin
                chk("wait_timeout", 64'(cyc), 64'(t));
                break;
            end
        end
    endtask

    task automatic end_section(input string name);
        apply_reset(1'b0);
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 256; a++) prog[a] = 8'h00;
    endtask

    task automatic set_ins(input logic [7:0] a, input logic [7:0] opc, input logic [7:0] arg);
        logic [7:0] a1;
        a1 = a + 8'd1;
        prog[a]  = opc;
        prog[a1] = arg;
    endtask

    initial begin
        int t0, te;
        clear_prog();
        m_pc = 8'h00;
        m_flags = 3'b000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_prog_addr", 64'(prog_addr), 64'h00);
        chk("reset_strobes", 64'({re, we, accl, flgl, srcimm, usec}), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_inst", 64'(inst), 64'h00);
        chk("reset_operand", 64'(operand), 64'h00);

        // Directed program: ADDI, ADD mem, JZ not taken, ADDI, JZ taken, LOADI, STOREI, ADC mem
        set_ins(8'h00, 8'h10, 8'h05);
        set_ins(8'h02, 8'h11, 8'h40);
        set_ins(8'h04, 8'h21, 8'h80);
        set_ins(8'h06, 8'h10, 8'h04);
        set_ins(8'h08, 8'h21, 8'h80);
        set_ins(8'h80, 8'h01, 8'h77);
        set_ins(8'h82, 8'h04, 8'h12);
        set_ins(8'h84, 8'h13, 8'h09);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_holds_pc", 64'(prog_addr), 64'h00);
        run = 1'b1;
        t0 = cyc + 1;
        model_run(8, t0, te);
        wait_until(te);
        end_section("drain_directed");

        // PC wrap at 0xFF, then an illegal opcode halts with PC frozen
        clear_prog();
        set_ins(8'h00, 8'h20, 8'hFF);
        prog[8'hFF] = 8'h01;
        apply_reset(1'b1);
        t0 = cyc + 1;
        model_run(10, t0, te);
        wait_until(te);
        repeat (10) @(negedge clk);
        chk("halt_pc_frozen", 64'(prog_addr), 64'h01);
        chk("halt_sticky", 64'(halted), 64'd1);
        end_section("drain_wrap_halt");

        // _iRun dropped mid-instruction, then raised again
        clear_prog();
        set_ins(8'h00, 8'h01, 8'h11);
        set_ins(8'h02, 8'h04, 8'h22);
        set_ins(8'h04, 8'h10, 8'h33);
        set_ins(8'h06, 8'h03, 8'h44);
        apply_reset(1'b1);
        t0 = cyc + 1;
        model_run(2, t0, te);
        wait_until(t0 + 5);
        run = 1'b0;
        wait_until(te + 8);
        chk("paused_pc", 64'(prog_addr), 64'h04);
        run = 1'b1;
        t0 = cyc + 1;
        model_run(2, t0, te);
        wait_until(te);
        end_section("drain_run_drop");

        // Reset asserted during EXEC of a store
        clear_prog();
        set_ins(8'h00, 8'h04, 8'h5A);
        apply_reset(1'b1);
        t0 = cyc + 1;
        model_run(1, t0, te);
        wait_until(t0 + 3);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_drops_we", 64'(we), 64'd0);
        chk("reset_mid_prog_addr", 64'(prog_addr), 64'h00);
        chk("reset_mid_inst", 64'(inst), 64'h00);
        chk("reset_mid_operand", 64'(operand), 64'h00);
        m_pc = 8'h00;
        m_flags = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc + 1;
        model_run(1, t0, te);
        wait_until(te);
        end_section("drain_reset_store");

        // Randomized programs: legal opcodes at even addresses, even jump targets
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 256; a += 2) begin
                prog[a]     = legal[$urandom_range(0, 13)];
                prog[a + 1] = 8'($urandom);
                if (prog[a] inside {8'h20, 8'h21, 8'h22, 8'h23})
                    prog[a + 1] = prog[a + 1] & 8'hFE;
            end
            apply_reset(1'b1);
            t0 = cyc + 1;
            model_run(30, t0, te);
            wait_until(te);
            end_section("drain_random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
